// File: rtl/wave_generator.sv
// Programmable pulse-train source: N pulses, each H cycles high then L cycles low.
// Configuration is latched on an accepted start. All outputs are registered.
module wave_generator #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] high_cycles,
  input  logic [W-1:0] low_cycles,
  input  logic [W-1:0] pulse_count,
  output logic         wave,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] phase_q, phase_d;
  logic [W-1:0] pulses_q, pulses_d;
  logic [W-1:0] h_q, h_d;
  logic [W-1:0] l_q, l_d;
  logic         wave_q, wave_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    pulses_d = pulses_q;
    h_d      = h_q;
    l_d      = l_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (high_cycles == '0 || low_cycles == '0 || pulse_count == '0) begin
            err_d = 1'b1;
          end else begin
            h_d      = high_cycles;
            l_d      = low_cycles;
            phase_d  = high_cycles;
            pulses_d = pulse_count;
            state_d  = HIGH;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_d = IDLE;
        end else if (phase_q == W'(1)) begin
          phase_d = l_q;
          state_d = LOW;
        end else begin
          phase_d = phase_q - W'(1);
        end
      end
      LOW: begin
        if (abort) begin
          state_d = IDLE;
        end else if (phase_q == W'(1)) begin
          pulses_d = pulses_q - W'(1);
          if (pulses_q == W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            phase_d = h_q;
            state_d = HIGH;
          end
        end else begin
          phase_d = phase_q - W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are derived from the next state so they line up with it after the edge.
    wave_d = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      pulses_q <= '0;
      h_q      <= '0;
      l_q      <= '0;
      wave_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      pulses_q <= pulses_d;
      h_q      <= h_d;
      l_q      <= l_d;
      wave_q   <= wave_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign wave = wave_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: doc/wave_generator.md
Name: wave_generator

Overview:
- Programmable pulse-train source: the transmitting counterpart to the frequency meter's pulse-width counter.
- On start, emits pulse_count pulses on wave. Each pulse is high for exactly high_cycles clk cycles, then low for exactly low_cycles clk cycles.
- Used as an on-chip stimulus for the measurement path and as a self-test source.

Parameters:
W, 32, width of high_cycles, low_cycles, pulse_count and the internal counters.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in Idle
abort  input  1  terminate the current train; sampled only when busy
high_cycles  input  W  high-phase length in clk cycles; latched on accepted start
low_cycles  input  W  low-phase length in clk cycles; latched on accepted start
pulse_count  input  W  number of pulses; latched on accepted start
wave  output  1  generated waveform, registered
busy  output  1  high while a train is in progress
done  output  1  one-cycle pulse when a train completes normally
err  output  1  one-cycle pulse when a start is rejected

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=Idle, wave=0, busy=0, done=0, err=0, all counters and latched config = 0.
- All outputs are registered. done and err are single-cycle pulses, 0 by default every cycle.
- States: Idle, High, Low (one-hot or encoded, implementer's choice).
- Idle:
  - wave=0, busy=0.
  - If start=1 and any of high_cycles, low_cycles, pulse_count is 0: err=1 next cycle, stay in Idle.
  - If start=1 and all three are nonzero: latch all three, load phase counter = high_cycles and pulses-remaining = pulse_count, go to High.
- Timing for an accepted start in cycle t (H = high_cycles, L = low_cycles, N = pulse_count):
  - wave=1 and busy=1 from cycle t+1.
  - The phase counter decrements each cycle. On the last high cycle, load L and go to Low.
  - wave=1 for exactly H cycles (t+1 .. t+H), then wave=0 for exactly L cycles.
- Low, last cycle:
  - Decrement pulses-remaining.
  - If pulses remain: reload H, go to High. No gap cycle between pulses; period = H+L exactly.
  - Otherwise: go to Idle.
- Completion: in cycle t+N*(H+L)+1, busy=0 and done=1.
- start during busy: ignored. No effect on config, no err.
- start in the cycle done=1 (state is Idle): accepted normally, so back-to-back trains are separated by exactly one idle cycle.
- abort=1 while busy:
  - Next cycle: state=Idle, wave=0, busy=0, done stays 0.
  - abort takes priority over any phase transition in the same cycle.
  - abort in Idle is ignored.
- Input changes to high_cycles, low_cycles, pulse_count while busy have no effect.
- rst mid-train: next cycle all outputs return to reset values regardless of state. rst has priority over start and abort.
- Maximum values:
  - H = L = 2^W-1 must work without wrap.
  - Counters are W bits, down-counting. A counter value of 1 marks the final cycle of a phase.
- Minimum legal values: H = L = 1 gives a 50% square wave of period 2.

Test Plan:
1. Basic timing: rst, then start with H=3, L=2, N=2 at cycle t -> wave=1 at t+1..t+3, 0 at t+4..t+5, 1 at t+6..t+8, 0 at t+9..t+10. busy=1 over t+1..t+10. At t+11: busy=0, done=1 for one cycle.
2. Minimum values: start with H=1, L=1, N=4 -> wave alternates 1,0 for 8 cycles. done at t+9. Pulse-width counter on this wave reads 1 per pulse.
3. Rejected start: start with H=5, L=0, N=3 -> err=1 for one cycle, busy stays 0, wave stays 0. Repeat with N=0 and with H=0: same result.
4. Abort and ignored start: start with H=10, L=10, N=5. Assert start again at t+4 with H=1 -> ignored, wave still high through t+10. Assert abort at t+15 -> at t+16 wave=0, busy=0, done=0. New start at t+16 is accepted.
5. Back-to-back: start H=2, L=2, N=1. Assert start again with H=4, L=1, N=1 in the done cycle -> second train wave=1 for 4 cycles beginning the cycle after.
6. Reset mid-train: assert rst during a High phase of an H=8, L=8, N=3 train -> next cycle wave=0, busy=0, done=0, err=0. No residual pulses afterward. start with rst=1 is not accepted.
